// File: rtl/collision_pkg.sv
// ---------------------------------------------------------------------------
// collision_pkg
// Shared types and constants for the enemy collision detector.
//   enemy_state_t  : life-cycle state of the enemy (ALIVE / DYING / DEAD)
//   HIT_COUNT_W    : width of the kill counter
//   HIT_COUNT_MAX  : value at which the kill counter saturates
//   sat_inc_hits() : saturating increment of the kill counter
// ---------------------------------------------------------------------------
package collision_pkg;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        DYING = 2'd1,
        DEAD  = 2'd2
    } enemy_state_t;

    localparam int                     HIT_COUNT_W   = 8;
    localparam logic [HIT_COUNT_W-1:0] HIT_COUNT_MAX = {HIT_COUNT_W{1'b1}};

    function automatic logic [HIT_COUNT_W-1:0] sat_inc_hits(input logic [HIT_COUNT_W-1:0] value);
        if (value == HIT_COUNT_MAX) begin
            return value;
        end
        return value + 1'b1;
    endfunction

endpackage

// File: rtl/frame_event_latch.sv
// ---------------------------------------------------------------------------
// frame_event_latch
// Turns a level event into at most one registered pulse per video frame.
// A sticky flag remembers that the event already fired in this frame; it is
// cleared by startOfFrame, and an event coincident with startOfFrame is
// treated as belonging to the new frame.
//   clk          : system clock
//   resetN       : asynchronous active-low reset
//   startOfFrame : one-cycle pulse at the first pixel of a frame
//   eventIn      : qualified event (already gated by the caller)
//   fire         : combinational "this event is accepted now"
//   pulse        : registered one-cycle pulse, one clock after acceptance
//   sticky       : event has already been accepted in the current frame
// ---------------------------------------------------------------------------
module frame_event_latch (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic eventIn,
    output logic fire,
    output logic pulse,
    output logic sticky
);

    logic sticky_reg;
    logic pulse_reg;

    // At startOfFrame the old flag no longer blocks: the event opens the new frame.
    assign fire = eventIn && (startOfFrame || !sticky_reg);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sticky_reg <= 1'b0;
            pulse_reg  <= 1'b0;
        end else begin
            sticky_reg <= (startOfFrame ? 1'b0 : sticky_reg) | eventIn;
            pulse_reg  <= fire;
        end
    end

    assign pulse  = pulse_reg;
    assign sticky = sticky_reg;

endmodule

// File: rtl/enemy_collision_detector.sv
// ---------------------------------------------------------------------------
// enemy_collision_detector
// Pixel-level collision detection between one enemy, NUM_SHOTS player shots
// and the playfield border.
//   clk                 : system clock
//   resetN              : asynchronous active-low reset
//   startOfFrame        : one-cycle pulse at the first pixel of each frame
//   enemyDrawingRequest : current pixel lies inside the enemy
//   shotDrawingRequest  : bit i set when current pixel lies inside shot i
//   borderDrawingRequest: current pixel is a border pixel
//   pause               : freezes all event generation and state
//   respawn             : level request to revive a dead enemy
//   shotCollision       : bit i pulses once per frame when shot i hits
//   changeDirection     : pulses when the enemy touches the border
//   enemyAlive          : enemy can currently be hit
//   hitCount            : saturating kill counter
// ---------------------------------------------------------------------------
module enemy_collision_detector
    import collision_pkg::*;
#(
    parameter int NUM_SHOTS       = 3,
    parameter int BORDER_COOLDOWN = 2
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   enemyDrawingRequest,
    input  logic [NUM_SHOTS-1:0]   shotDrawingRequest,
    input  logic                   borderDrawingRequest,
    input  logic                   pause,
    input  logic                   respawn,
    output logic [NUM_SHOTS-1:0]   shotCollision,
    output logic                   changeDirection,
    output logic                   enemyAlive,
    output logic [HIT_COUNT_W-1:0] hitCount
);

    localparam int CD_W = (BORDER_COOLDOWN < 1) ? 1 : $clog2(BORDER_COOLDOWN + 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(BORDER_COOLDOWN);

    // Index NUM_SHOTS of these vectors is the border channel.
    logic [NUM_SHOTS:0] event_vec;
    logic [NUM_SHOTS:0] fire_vec;
    logic [NUM_SHOTS:0] pulse_vec;
    logic [NUM_SHOTS:0] sticky_vec;

    enemy_state_t           state_reg, state_next;
    logic [HIT_COUNT_W-1:0] hit_count_reg, hit_count_next;
    logic [CD_W-1:0]        cooldown_reg, cooldown_next, cooldown_frame;

    logic hit_gate;
    logic any_hit;

    assign enemyAlive = (state_reg == ALIVE);
    assign hit_gate   = enemyDrawingRequest && enemyAlive && !pause;

    // Cooldown value that applies to the current cycle. The frame in which
    // the border event fired does not count as a cooldown frame, so the
    // counter only steps down at a frame start whose previous frame had no
    // accepted border event.
    always_comb begin
        cooldown_frame = cooldown_reg;
        if (startOfFrame && !sticky_vec[NUM_SHOTS] && (cooldown_reg != '0)) begin
            cooldown_frame = cooldown_reg - 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SHOTS; gi++) begin : g_shot_event
            assign event_vec[gi] = hit_gate && shotDrawingRequest[gi];
        end
    endgenerate

    assign event_vec[NUM_SHOTS] = hit_gate && borderDrawingRequest && (cooldown_frame == '0);

    generate
        for (genvar gi = 0; gi <= NUM_SHOTS; gi++) begin : g_latch
            frame_event_latch u_latch (
                .clk          (clk),
                .resetN       (resetN),
                .startOfFrame (startOfFrame),
                .eventIn      (event_vec[gi]),
                .fire         (fire_vec[gi]),
                .pulse        (pulse_vec[gi]),
                .sticky       (sticky_vec[gi])
            );
        end
    endgenerate

    assign shotCollision   = pulse_vec[NUM_SHOTS-1:0];
    assign changeDirection = pulse_vec[NUM_SHOTS];

    // The enemy leaves ALIVE on the same edge that registers the pulses, so
    // every shot overlapping in that first cycle still gets its pulse while
    // any later overlap is already masked by enemyAlive.
    assign any_hit = |fire_vec[NUM_SHOTS-1:0];

    always_comb begin
        state_next     = state_reg;
        hit_count_next = hit_count_reg;
        cooldown_next  = cooldown_frame;

        if (fire_vec[NUM_SHOTS]) begin
            cooldown_next = CD_LOAD;
        end

        if (!pause) begin
            unique case (state_reg)
                ALIVE: begin
                    if (any_hit) begin
                        state_next     = DYING;
                        hit_count_next = sat_inc_hits(hit_count_reg);
                    end
                end
                DYING: begin
                    if (startOfFrame) begin
                        state_next = DEAD;
                    end
                end
                DEAD: begin
                    if (startOfFrame && respawn) begin
                        state_next = ALIVE;
                    end
                end
                default: state_next = ALIVE;
            endcase
        end else begin
            cooldown_next = cooldown_reg;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg     <= ALIVE;
            hit_count_reg <= '0;
            cooldown_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            hit_count_reg <= hit_count_next;
            cooldown_reg  <= cooldown_next;
        end
    end

    assign hitCount = hit_count_reg;

endmodule

// File: tb/tb_enemy_collision_detector.sv
module tb_enemy_collision_detector;

    localparam int NS = 3;
    localparam int CD = 2;

    logic          clk;
    logic          resetN;
    logic          startOfFrame;
    logic          enemyDrawingRequest;
    logic [NS-1:0] shotDrawingRequest;
    logic          borderDrawingRequest;
    logic          pause;
    logic          respawn;
    logic [NS-1:0] shotCollision;
    logic          changeDirection;
    logic          enemyAlive;
    logic [7:0]    hitCount;

    int checks   = 0;
    int failures = 0;

    enemy_collision_detector #(.NUM_SHOTS(NS), .BORDER_COOLDOWN(CD)) dut (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .enemyDrawingRequest  (enemyDrawingRequest),
        .shotDrawingRequest   (shotDrawingRequest),
        .borderDrawingRequest (borderDrawingRequest),
        .pause                (pause),
        .respawn              (respawn),
        .shotCollision        (shotCollision),
        .changeDirection      (changeDirection),
        .enemyAlive           (enemyAlive),
        .hitCount             (hitCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: frame-numbered bookkeeping rather than a state machine.
    int          m_frame;
    int          m_last_border;
    int          m_died_frame;
    bit          m_alive;
    int          m_kills;
    bit [NS-1:0] m_seen;
    logic [NS-1:0] exp_shot;
    logic          exp_cd;

    int cd_tally [0:4];
    int frame_tag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_frame       = 0;
        m_last_border = -100;
        m_died_frame  = -100;
        m_alive       = 1'b1;
        m_kills       = 0;
        m_seen        = '0;
    endtask

    task automatic model_step(input logic sof, input logic en, input logic [NS-1:0] sh,
                              input logic bd, input logic ps, input logic rs);
        bit alive_now;
        alive_now = m_alive;
        exp_shot  = '0;
        exp_cd    = 1'b0;
        if (sof) begin
            m_frame++;
            m_seen = '0;
        end
        if (en && alive_now && !ps) begin
            exp_shot = sh & ~m_seen;
            m_seen   = m_seen | sh;
            // Border accepted only once the CD frames following the last event have passed.
            if (bd && (m_frame - m_last_border > CD)) begin
                exp_cd        = 1'b1;
                m_last_border = m_frame;
            end
        end
        if (exp_shot != '0) begin
            m_alive      = 1'b0;
            m_died_frame = m_frame;
            if (m_kills < 255) m_kills++;
        end else if (sof && !ps && !alive_now && rs && (m_frame >= m_died_frame + 2)) begin
            m_alive = 1'b1;
        end
    endtask

    // One clock cycle: drive inputs, advance the model, sample after the edge.
    task automatic cycle(input logic sof, input logic en, input logic [NS-1:0] sh,
                         input logic bd, input logic ps, input logic rs);
        startOfFrame         = sof;
        enemyDrawingRequest  = en;
        shotDrawingRequest   = sh;
        borderDrawingRequest = bd;
        pause                = ps;
        respawn              = rs;
        model_step(sof, en, sh, bd, ps, rs);
        @(posedge clk);
        #1;
        chk("shotCollision", 32'(shotCollision), 32'(exp_shot));
        chk("changeDirection", 32'(changeDirection), 32'(exp_cd));
        chk("enemyAlive", 32'(enemyAlive), 32'(m_alive));
        chk("hitCount", 32'(hitCount), 32'(m_kills));
        if (changeDirection && frame_tag >= 0 && frame_tag <= 4) cd_tally[frame_tag]++;
        $display("t=%0t sof=%b en=%b sh=%b bd=%b ps=%b rs=%b -> shot=%b cd=%b alive=%b hits=%0d",
                 $time, sof, en, sh, bd, ps, rs, shotCollision, changeDirection, enemyAlive, hitCount);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        startOfFrame         = 1'b0;
        enemyDrawingRequest  = 1'b0;
        shotDrawingRequest   = '0;
        borderDrawingRequest = 1'b0;
        pause                = 1'b0;
        respawn              = 1'b0;
        resetN               = 1'b0;
        #1;
        chk("reset_shotCollision", 32'(shotCollision), 32'd0);
        chk("reset_changeDirection", 32'(changeDirection), 32'd0);
        chk("reset_enemyAlive", 32'(enemyAlive), 32'd1);
        chk("reset_hitCount", 32'(hitCount), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        model_reset();
        frame_tag = -1;
    endtask

    initial begin
        resetN = 1'b0;
        frame_tag = -1;
        for (int i = 0; i <= 4; i++) cd_tally[i] = 0;
        #2;
        do_reset();

        // Shot 0 overlaps on 5 consecutive pixels: one pulse, enemy dies, one kill.
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
        chk("s1_first_pulse", 32'(shotCollision), 32'b001);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("s1_alive", 32'(enemyAlive), 32'd0);
        chk("s1_hits", 32'(hitCount), 32'd1);

        // Shots 0 and 2 together.
        do_reset();
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
        chk("s2_pulse", 32'(shotCollision), 32'b101);
        cycle(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
        chk("s2_no_second", 32'(shotCollision), 32'b000);
        idle(2);
        chk("s2_hits", 32'(hitCount), 32'd1);

        // Border overlaps in four frames with cooldown of two frames.
        do_reset();
        for (int f = 1; f <= 4; f++) begin
            frame_tag = f;
            cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
            idle(2);
            for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0, 1'b1, 1'b0, 1'b0);
            idle(3);
        end
        chk("s3_frame1", 32'(cd_tally[1]), 32'd1);
        chk("s3_frame2", 32'(cd_tally[2]), 32'd0);
        chk("s3_frame3", 32'(cd_tally[3]), 32'd0);
        chk("s3_frame4", 32'(cd_tally[4]), 32'd1);
        frame_tag = -1;

        // Kill, die, respawn on a frame start, then a second kill.
        do_reset();
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
        idle(3);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("s4_not_before_sof", 32'(enemyAlive), 32'd0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("s4_alive_on_sof", 32'(enemyAlive), 32'd1);
        idle(3);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("s4_hits", 32'(hitCount), 32'd2);

        // Pause masks an overlap; the overlap repeats unpaused in the same frame.
        do_reset();
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 3'b100, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("s5_paused_hits", 32'(hitCount), 32'd0);
        cycle(1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
        chk("s5_pulse", 32'(shotCollision), 32'b100);
        idle(1);

        // Reset while a pulse is pending.
        do_reset();
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        startOfFrame         = 1'b0;
        enemyDrawingRequest  = 1'b1;
        shotDrawingRequest   = 3'b001;
        @(negedge clk);
        resetN = 1'b0;
        @(posedge clk);
        #1;
        chk("s6_no_pulse", 32'(shotCollision), 32'd0);
        chk("s6_hits", 32'(hitCount), 32'd0);
        chk("s6_alive", 32'(enemyAlive), 32'd1);
        do_reset();

        // Randomized frames against the model.
        for (int f = 0; f < 40; f++) begin
            for (int c = 0; c < 20; c++) begin
                logic          r_ps;
                logic [NS-1:0] r_sh;
                r_ps = (c != 0) && ($urandom_range(0, 9) == 0);
                for (int b = 0; b < NS; b++) r_sh[b] = ($urandom_range(0, 3) == 0);
                cycle(c == 0, 1'($urandom_range(0, 1)), r_sh,
                      $urandom_range(0, 4) == 0, r_ps, $urandom_range(0, 2) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/enemy_collision_detector.md
ENEMY_COLLISION_DETECTOR -- requirements
Module: enemy_collision_detector

Interface
REQ-001 SHALL have parameter NUM_SHOTS, default 3, number of independent player shots checked against the enemy.
REQ-002 SHALL have parameter BORDER_COOLDOWN, default 2, number of frames after a border event during which further border events are suppressed.
REQ-003 SHALL have port clk, input, 1, system clock; the block uses this single clock only.
REQ-004 SHALL have port resetN, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port startOfFrame, input, 1, one-cycle pulse at the first pixel of each VGA frame.
REQ-006 SHALL have port enemyDrawingRequest, input, 1, high when the current pixel is inside the enemy bracket.
REQ-007 SHALL have port shotDrawingRequest, input, NUM_SHOTS, bit i high when the current pixel is inside shot i.
REQ-008 SHALL have port borderDrawingRequest, input, 1, high when the current pixel is a playfield border pixel.
REQ-009 SHALL have port pause, input, 1, freezes event generation while high.
REQ-010 SHALL have port respawn, input, 1, level request to return a dead enemy to life.
REQ-011 SHALL have port shotCollision, output, NUM_SHOTS, bit i is a one-cycle pulse when shot i hits the enemy.
REQ-012 SHALL have port changeDirection, output, 1, one-cycle pulse when the enemy touches the border.
REQ-013 SHALL have port enemyAlive, output, 1, high while the enemy can be hit.
REQ-014 SHALL have port hitCount, output, 8, saturating count of kills since reset.

Function
REQ-015 SHALL detect a hit on shot i in any cycle where enemyDrawingRequest && shotDrawingRequest[i] && enemyAlive && !pause.
REQ-016 SHALL pulse shotCollision[i] high for exactly one cycle, registered, one clock after the first detected hit on shot i in a frame.
REQ-017 SHALL suppress further shotCollision[i] pulses until the next startOfFrame, using a per-shot sticky flag.
REQ-018 SHALL raise, on simultaneous hits by several shots in one cycle, all the corresponding shotCollision bits in the same cycle.
REQ-019 SHALL implement an FSM with states ALIVE, DYING and DEAD.
REQ-020 SHALL move ALIVE -> DYING in the cycle any shotCollision bit pulses.
REQ-021 SHALL move DYING -> DEAD on the next startOfFrame.
REQ-022 SHALL move DEAD -> ALIVE on a startOfFrame that coincides with respawn high; respawn at any other time is ignored.
REQ-023 SHALL drive enemyAlive = 1 only in state ALIVE.
REQ-024 SHALL, in DYING, still let hits that arrived in the same cycle as the first hit generate their pulses, and SHALL ignore all later hits.
REQ-025 SHALL detect a border event when enemyDrawingRequest && borderDrawingRequest && enemyAlive && !pause.
REQ-026 SHALL pulse changeDirection for exactly one cycle, one clock after the first border event in a frame.
REQ-027 SHALL then load a frame cooldown counter with BORDER_COOLDOWN and decrement it at each startOfFrame, saturating at 0.
REQ-028 SHALL suppress border events while the cooldown counter is nonzero.
REQ-029 SHALL clear all sticky flags at startOfFrame; an overlap in the same cycle as startOfFrame counts toward the new frame.
REQ-030 SHALL increment hitCount by exactly 1 on each ALIVE -> DYING transition and hold it at 255 (saturate).
REQ-031 SHALL, while pause is high, generate no pulses, set no flags, and leave the FSM and cooldown counter unchanged.
REQ-032 SHALL let a pulse already registered when pause rises complete normally.

Reset
REQ-033 SHALL, on resetN low, asynchronously force: shotCollision = 0, changeDirection = 0, FSM = ALIVE (enemyAlive = 1), hitCount = 0, cooldown = 0, all sticky flags = 0.
REQ-034 SHALL, on reset asserted mid-frame, discard any pending pulse; the first frame after reset behaves as a normal frame from the next cycle on.

Structure
REQ-035 SHALL place the FSM state enum and the hitCount width/saturation constants in a shared package, collision_pkg.
REQ-036 SHALL implement the per-frame once-only pulse (sticky flag plus registered pulse, cleared by startOfFrame) as sub-module frame_event_latch, instantiated NUM_SHOTS+1 times.

Verification
REQ-037 SHALL cover this scenario: shot 0 overlaps the enemy on 5 consecutive pixels in frame 1 -> exactly one shotCollision[0] pulse, one cycle after the first overlap; enemyAlive falls; hitCount = 1.
REQ-038 SHALL cover this scenario: shots 0 and 2 overlap the enemy in the same cycle -> shotCollision = 3'b101 for one cycle; hitCount = 1.
REQ-039 SHALL cover this scenario: border overlaps in frames 1, 2, 3 and 4 with BORDER_COOLDOWN=2 -> changeDirection pulses in frames 1 and 4 only.
REQ-040 SHALL cover this scenario: enemy DEAD, respawn held high mid-frame, then startOfFrame -> enemyAlive rises on that startOfFrame, not before; a hit in the next frame gives hitCount = 2.
REQ-041 SHALL cover this scenario: pause high during a shot overlap -> no pulse; pause low and the overlap repeats in the same frame -> one pulse.
REQ-042 SHALL cover this scenario: resetN low one cycle after a hit (pulse pending) -> no pulse emitted; hitCount = 0; enemyAlive = 1.
